// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side control logic: FSM state encoding,
// a constant-evaluable clog2 and the default FIFO word width.
package fifo_ctrl_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_XFER = 1'b1;

    // Number of bits needed to index 'value' distinct items (minimum 0)
    function automatic int clog2(input int value);
        int res;
        int rem;
        res = 32'sd0;
        rem = value - 32'sd1;
        while (rem > 32'sd0) begin
            res = res + 32'sd1;
            rem = rem >>> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: scans last+1, last+2, ... (mod N)
// and returns the first requesting index as a one-hot vector.
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  pick,
    output logic          valid
);

    logic [IW-1:0] idx_s;
    logic          hit_s;

    // Walk the ring once starting just after the previous owner
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx_s = '0;
        hit_s = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s       = IW'((int'(last) + k) % N);
            hit_s       = req[idx_s] & ~valid;
            pick[idx_s] = hit_s;
            valid       = valid | hit_s;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the async FIFO write port with bounded bursts.
// Optional WARB_STALL_CNT_EN adds a saturating count of full-stalled cycles.
module fifo_write_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_MAX  = 4
) (
    input  logic                          wclk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
`ifdef WARB_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int IDX_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BURST_MAX - 1);
    localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

    logic [0:0]         state_r;
    logic [0:0]         state_nxt_s;
    logic [NUM_REQ-1:0] grant_r;
    logic               busy_r;
    logic [CNT_W-1:0]   burst_cnt_r;
    logic [IDX_W-1:0]   last_r;
    logic [NUM_REQ-1:0] pick_s;
    logic               pick_valid_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic               owner_req_s;
    logic               w_en_s;
    logic               burst_done_s;
    logic               end_burst_s;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .last  (last_r),
        .pick  (pick_s),
        .valid (pick_valid_s)
    );

    // Owner decode, write qualification and end-of-burst detection
    always_comb begin
        grant_idx_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_idx_s = grant_idx_s | ({IDX_W{grant_r[i]}} & IDX_W'(i));
        end
        owner_req_s  = |(req & grant_r);
        w_en_s       = (state_r == ST_XFER) & owner_req_s & ~fifo_full;
        burst_done_s = w_en_s & (burst_cnt_r == CNT_LAST);
        end_burst_s  = (state_r == ST_XFER) & (~owner_req_s | burst_done_s);
    end

    // FSM state register
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    state_nxt_s = ST_XFER;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (end_burst_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FIFO-side outputs; data is gated to zero whenever nobody owns the port
    always_comb begin
        fifo_data_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_data_in = fifo_data_in |
                ({DATA_WIDTH{grant_r[i] & (state_r == ST_XFER)}} &
                 req_data[i*DATA_WIDTH +: DATA_WIDTH]);
        end
        fifo_w_en = w_en_s;
        ack       = grant_r & {NUM_REQ{w_en_s}};
    end

    // Grant, busy, burst counter and rotation pointer
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            grant_r     <= '0;
            busy_r      <= 1'b0;
            burst_cnt_r <= '0;
            last_r      <= LAST_INIT;
        end else if (state_r == ST_IDLE) begin
            if (pick_valid_s) begin
                grant_r     <= pick_s;
                busy_r      <= 1'b1;
                burst_cnt_r <= '0;
            end
        end else begin
            if (w_en_s) begin
                burst_cnt_r <= burst_cnt_r + CNT_W'(1);
            end
            if (end_burst_s) begin
                grant_r <= '0;
                busy_r  <= 1'b0;
                last_r  <= grant_idx_s;
            end
        end
    end

    assign grant = grant_r;
    assign busy  = busy_r;

`ifdef WARB_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    // Saturating count of cycles the owner was held off by a full FIFO
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'h0000;
        end else if ((state_r == ST_XFER) & owner_req_s & fifo_full &
                     (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

endmodule
